// File: rtl/arb_pkg.sv
// ---------------------------------------------------------------------------
// arb_pkg
//   Shared definitions for the round-robin bus arbiter:
//     - IDX_W   : grant index width (select width of the 4:16 decoder)
//     - MAX_REQ : number of decoder output lines
//     - arb_state_e : arbiter FSM state encoding
//     - dec4to16    : the 4:16 decoder (s, en) that the grant index drives
// ---------------------------------------------------------------------------
package arb_pkg;

    localparam int IDX_W   = 4;
    localparam int MAX_REQ = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } arb_state_e;

    // 4:16 decoder: one line high for select s when en is set.
    function automatic logic [MAX_REQ-1:0] dec4to16(input logic [IDX_W-1:0] s,
                                                    input logic             en);
        dec4to16 = en ? (MAX_REQ'(1) << s) : '0;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin winner selection. Rotates the request vector
//   so that bit ptr lands at position 0, priority-encodes the lowest set bit,
//   and adds ptr back (mod N) to recover the absolute requester index.
// Ports
//   req [N-1:0]     in   request lines
//   ptr [IDX_W-1:0] in   highest-priority requester (always < N)
//   any             out  at least one request is set
//   idx [IDX_W-1:0] out  winning requester index (valid when any=1)
// ---------------------------------------------------------------------------
module rr_pick
    import arb_pkg::*;
#(
    parameter int N = 16
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic             any,
    output logic [IDX_W-1:0] idx
);

    localparam logic [IDX_W:0] N_W = (IDX_W+1)'(N);

    logic [N-1:0]     rot;
    logic [IDX_W-1:0] off;
    logic [IDX_W:0]   sum;

    always_comb begin
        // NOTE: every variable gets a default before any conditional
        // assignment so the block stays purely combinational (no latches).
        any = 1'b0;
        off = '0;
        // Doubling the vector makes the rotate a plain shift; ptr < N keeps
        // the wrapped bits in the low N positions.
        rot = N'({req, req} >> ptr);
        // Scan downward so the lowest set bit (nearest to ptr) wins.
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                any = 1'b1;
                off = IDX_W'(i);
            end
        end
        // Explicit mod-N wrap: N need not be a power of two.
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= N_W) begin
            sum = sum - N_W;
        end
        idx = sum[IDX_W-1:0];
    end

endmodule

// File: rtl/rr_bus_arbiter.sv
// ---------------------------------------------------------------------------
// rr_bus_arbiter
//   Round-robin arbiter sharing one bus among up to 16 requesters. The owner
//   keeps the grant until it pulses done, drops its request, or holds it for
//   MAX_HOLD cycles (forced release, flagged on timeout). Every release is
//   followed by one dead TURN cycle, and priority rotates to the requester
//   just above the previous owner.
// Ports
//   clk       in   rising-edge clock
//   reset     in   synchronous active-high reset
//   req       in   [N-1:0] level requests, held until served
//   done      in   owner-release pulse, ignored unless gnt_valid=1
//   gnt_valid out  grant active (decoder en)
//   gnt_idx   out  [IDX_W-1:0] current/last owner (decoder s)
//   gnt       out  [N-1:0] registered one-hot grant
//   timeout   out  one-cycle pulse on a forced release
// ---------------------------------------------------------------------------
module rr_bus_arbiter
    import arb_pkg::*;
#(
    parameter int N        = 16,
    parameter int MAX_HOLD = 64,
    parameter int CNT_W    = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     req,
    input  logic             done,
    output logic             gnt_valid,
    output logic [IDX_W-1:0] gnt_idx,
    output logic [N-1:0]     gnt,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N - 1);

    arb_state_e       state_q,     state_d;
    logic [IDX_W-1:0] ptr_q,       ptr_d;
    logic [CNT_W-1:0] hold_cnt_q,  hold_cnt_d;
    logic             gnt_valid_q, gnt_valid_d;
    logic [IDX_W-1:0] gnt_idx_q,   gnt_idx_d;
    logic [N-1:0]     gnt_q,       gnt_d;
    logic             timeout_q,   timeout_d;

    logic             pick_any;
    logic [IDX_W-1:0] pick_idx;
    logic             owner_req;
    logic             rel_done;
    logic             rel_drop;
    logic             rel_hold;
    logic [MAX_REQ-1:0] dec_lines;

    rr_pick #(.N(N)) u_pick (
        .req (req),
        .ptr (ptr_q),
        .any (pick_any),
        .idx (pick_idx)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        hold_cnt_d  = hold_cnt_q;
        gnt_idx_d   = gnt_idx_q;
        gnt_valid_d = 1'b0;
        timeout_d   = 1'b0;

        // Request line of the current owner, selected without an index wider
        // than the request vector.
        owner_req = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (gnt_idx_q == IDX_W'(i)) begin
                owner_req = req[i];
            end
        end

        rel_done = done;
        rel_drop = !owner_req;
        rel_hold = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST);

        unique case (state_q)
            GRANT: begin
                gnt_valid_d = 1'b1;
                hold_cnt_d  = hold_cnt_q + CNT_W'(1);
                if (rel_done || rel_drop || rel_hold) begin
                    state_d     = TURN;
                    gnt_valid_d = 1'b0;
                    ptr_d       = (gnt_idx_q == LAST_IDX) ? '0 : gnt_idx_q + IDX_W'(1);
                    // A voluntary release wins over a coinciding timeout.
                    timeout_d   = rel_hold && !rel_done && !rel_drop;
                end
            end
            default: begin
                // IDLE and TURN arbitrate identically.
                hold_cnt_d = '0;
                if (pick_any) begin
                    state_d     = GRANT;
                    gnt_valid_d = 1'b1;
                    gnt_idx_d   = pick_idx;
                end else begin
                    state_d     = IDLE;
                end
            end
        endcase

        // Decode the next index/valid so gnt lines up with gnt_valid/gnt_idx.
        dec_lines = dec4to16(gnt_idx_d, gnt_valid_d);
        gnt_d     = dec_lines[N-1:0];
    end

    // NOTE: reset is synchronous here, so it is tested inside the clocked
    // branch rather than listed in the sensitivity list.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            hold_cnt_q  <= '0;
            gnt_valid_q <= 1'b0;
            gnt_idx_q   <= '0;
            gnt_q       <= '0;
            timeout_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            hold_cnt_q  <= hold_cnt_d;
            gnt_valid_q <= gnt_valid_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_q       <= gnt_d;
            timeout_q   <= timeout_d;
        end
    end

    assign gnt_valid = gnt_valid_q;
    assign gnt_idx   = gnt_idx_q;
    assign gnt       = gnt_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rr_bus_arbiter
//   Directed scenarios followed by a randomized phase. Each cycle a
//   behavioural model (owner / cycles-held / priority pointer, mod-N scan)
//   predicts the outputs, which are compared at the falling edge.
// ---------------------------------------------------------------------------
module tb_rr_bus_arbiter;

    localparam int N    = 16;
    localparam int MAXH = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  req;
    logic          done;
    logic          gnt_valid;
    logic [3:0]    gnt_idx;
    logic [N-1:0]  gnt;
    logic          timeout;

    int checks   = 0;
    int failures = 0;

    // Reference model state.
    bit m_busy;
    int m_owner;
    int m_ptr;
    int m_held;
    bit m_to;

    always #5 clk = ~clk;

    rr_bus_arbiter #(.N(N), .MAX_HOLD(MAXH), .CNT_W(7)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .done      (done),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx),
        .gnt       (gnt),
        .timeout   (timeout)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // One clock of the specified behaviour, computed from the rules directly.
    task automatic model_step(input logic [N-1:0] r, input logic d, input logic rst);
        bit timed_out;
        if (rst) begin
            m_busy  = 0;
            m_owner = 0;
            m_ptr   = 0;
            m_held  = 0;
            m_to    = 0;
        end else if (m_busy) begin
            m_held    = m_held + 1;
            timed_out = (MAXH != 0) && (m_held == MAXH);
            m_to      = 0;
            if (d || !r[m_owner] || timed_out) begin
                m_to   = timed_out && !d && r[m_owner];
                m_busy = 0;
                m_ptr  = (m_owner + 1) % N;
            end
        end else begin
            m_to = 0;
            for (int k = 0; k < N; k++) begin
                if (!m_busy && r[(m_ptr + k) % N]) begin
                    m_busy  = 1;
                    m_owner = (m_ptr + k) % N;
                    m_held  = 0;
                end
            end
        end
    endtask

    task automatic tick();
        logic [N-1:0] exp_gnt;
        @(posedge clk);
        model_step(req, done, reset);
        @(negedge clk);
        exp_gnt = m_busy ? (N'(1) << m_owner) : '0;
        check("gnt_valid", 32'(gnt_valid), 32'(m_busy));
        check("gnt_idx",   32'(gnt_idx),   32'(m_owner));
        check("gnt",       32'(gnt),       32'(exp_gnt));
        check("timeout",   32'(timeout),   32'(m_to));
    endtask

    // Advance until a grant is visible, bounded.
    task automatic wait_grant(input string tag);
        int n = 0;
        while (gnt_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        assert (gnt_valid === 1'b1) else begin
            failures++;
            $error("FAIL %s: no grant within 20 cycles", tag);
        end
    endtask

    // Expect a grant to exp_idx, hold it one cycle, then release with done.
    task automatic grant_with_done(input string tag, input int exp_idx);
        wait_grant(tag);
        check({tag, "_idx"}, 32'(gnt_idx), 32'(exp_idx));
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        check({tag, "_dead"}, 32'(gnt_valid), 32'd0);
    endtask

    initial begin
        int cnt;
        reset = 1'b1;
        req   = '0;
        done  = 1'b0;

        // 1. Reset with all requests high.
        req = 16'hFFFF;
        repeat (3) tick();
        check("rst_valid", 32'(gnt_valid), 32'd0);
        check("rst_gnt",   32'(gnt),       32'd0);
        check("rst_idx",   32'(gnt_idx),   32'd0);
        reset = 1'b0;
        tick();
        check("t1_valid", 32'(gnt_valid), 32'd1);
        check("t1_idx",   32'(gnt_idx),   32'd0);

        // 2. Alternation between 0 and 2.
        req = 16'h0005;
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        check("t2_dead0", 32'(gnt_valid), 32'd0);
        grant_with_done("t2_g2a", 2);
        grant_with_done("t2_g0",  0);
        grant_with_done("t2_g2b", 2);
        req = '0;
        repeat (2) tick();

        // 3. Hold timeout.
        req = 16'h0008;
        wait_grant("t3_grant");
        cnt = 0;
        while (gnt_valid === 1'b1 && cnt < 20) begin
            cnt++;
            tick();
        end
        check("t3_hold_cycles", 32'(cnt),     32'(MAXH));
        check("t3_timeout",     32'(timeout), 32'd1);
        tick();
        check("t3_regrant",     32'(gnt_valid), 32'd1);
        check("t3_regrant_idx", 32'(gnt_idx),   32'd3);
        tick();
        check("t3_to_pulse",    32'(timeout),   32'd0);
        req = '0;
        repeat (2) tick();

        // 4. Wrap 14 -> 15 -> 0.
        req = 16'h4000;
        wait_grant("t4_g14");
        check("t4_idx14", 32'(gnt_idx), 32'd14);
        req = 16'h8001;
        tick();
        check("t4_drop14", 32'(gnt_valid), 32'd0);
        grant_with_done("t4_g15", 15);
        wait_grant("t4_g0");
        check("t4_idx0", 32'(gnt_idx), 32'd0);
        req = '0;
        repeat (2) tick();

        // 5. Owner 5 drops its request.
        req = 16'h0020;
        wait_grant("t5_g5");
        check("t5_idx5", 32'(gnt_idx), 32'd5);
        tick();
        req = 16'h0041;
        tick();
        check("t5_release", 32'(gnt_valid), 32'd0);
        check("t5_no_to",   32'(timeout),   32'd0);
        tick();
        check("t5_idx6", 32'(gnt_idx), 32'd6);
        req = '0;
        repeat (2) tick();

        // 6. Reset during grant 9.
        req = 16'h0200;
        wait_grant("t6_g9");
        check("t6_idx9", 32'(gnt_idx), 32'd9);
        reset = 1'b1;
        tick();
        check("t6_valid", 32'(gnt_valid), 32'd0);
        check("t6_gnt",   32'(gnt),       32'd0);
        check("t6_to",    32'(timeout),   32'd0);
        reset = 1'b0;
        req   = 16'h0201;
        tick();
        check("t6_idx0", 32'(gnt_idx), 32'd0);

        // Randomized phase against the model.
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 7) == 0) req = N'($urandom) & N'($urandom);
            else if ($urandom_range(0, 5) == 0) req = N'($urandom);
            done  = ($urandom_range(0, 3) == 0);
            reset = ($urandom_range(0, 63) == 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
